// File: rtl/if_prefetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer and its request/response
// interfaces to instruction memory.
package if_prefetch_buf_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } type_if2imem_s;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } type_imem2if_s;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } type_pf_entry_s;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_prefetch_buf_fifo.sv
// Synchronous FIFO of prefetched {pc, instr} entries with flush.
// The head reads as zero while empty.
module pf_sync_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  type_pf_entry_s               push_data,
  input  logic                         pop,
  output type_pf_entry_s               head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  type_pf_entry_s  mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
    valid   = (count != '0);
    head    = valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch queue: issues sequential word fetches ahead of the core,
// buffers responses, and drops responses belonging to a redirected-away stream.
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        pf_ready_i,
  output logic        pf_valid_o,
  output logic [31:0] pf_instr_o,
  output logic [31:0] pf_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned LW = CW + OW + 1;

  type_if2imem_s   imem_req;
  type_imem2if_s   imem_rsp;
  type_pf_entry_s  push_data;
  type_pf_entry_s  head;
  logic [31:0]     fetch_pc;
  logic [31:0]     resp_pc;
  logic [31:0]     redirect_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_nxt;
  logic [OW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [LW-1:0]   live;
  logic            run;
  logic            grant;
  logic            rvalid;
  logic            push;
  logic            head_valid;

  assign imem_rsp    = '{gnt: mem_gnt_i, rvalid: mem_rvalid_i, rdata: mem_rdata_i};
  assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Space is reserved for every live (non-discarded) request so the FIFO cannot overflow.
  always_comb begin
    live            = LW'(count) + LW'(outstanding) - LW'(discard);
    imem_req.req    = run && !redirect_i && (live < LW'(DEPTH)) &&
                      (outstanding < OW'(MAX_OUTSTANDING));
    imem_req.addr   = fetch_pc;
    grant           = imem_req.req && imem_rsp.gnt;
    rvalid          = imem_rsp.rvalid && (outstanding != '0);
    push            = rvalid && (discard == '0) && !redirect_i;
    outstanding_nxt = outstanding + OW'(grant) - OW'(rvalid);
    push_data       = '{pc: resp_pc, instr: imem_rsp.rdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (rvalid && (discard != '0)) discard <= discard - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!mem_rvalid_i || (outstanding != '0));
      assert (discard <= outstanding);
    end
  end

  pf_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pf_ready_i),
    .head      (head),
    .valid     (head_valid),
    .count     (count)
  );

  assign mem_req_o  = imem_req.req;
  assign mem_addr_o = imem_req.addr;
  assign pf_valid_o = head_valid;
  assign pf_pc_o    = head.pc;
  assign pf_instr_o = head.instr;

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Bench for if_prefetch_buf: directed vector table, corner sequences and a
// randomized run against a queue-based reference model of the fetch stream.
module tb_if_prefetch_buf;
  import if_prefetch_buf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        pf_ready_i = 1'b0;
  logic        pf_valid_o;
  logic [31:0] pf_instr_o;
  logic [31:0] pf_pc_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  if_prefetch_buf #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .pf_ready_i(pf_ready_i), .pf_valid_o(pf_valid_o), .pf_instr_o(pf_instr_o),
    .pf_pc_o(pf_pc_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Reference model: memory keeps in-order requests tagged with the stream epoch
  // they were issued in; the core-side queue holds PCs of kept responses.
  typedef struct { logic [31:0] addr; int unsigned epoch; int unsigned due; } req_t;
  req_t        pending[$];
  logic [31:0] mq[$];
  logic [31:0] grant_log[$];
  int unsigned epoch = 0, cyc = 0, pops = 0;
  int unsigned gnt_pct = 100, ready_pct = 0, lat_min = 0, lat_max = 0;
  logic [31:0] exp_fetch = RESET_PC;
  bit          started = 0;

  function automatic int unsigned live_pending();
    int unsigned n = 0;
    foreach (pending[i]) if (pending[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic cycle(input bit redir, input logic [31:0] rpc);
    req_t r;
    bit rv, keep, grant, popping, exp_req;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    pf_ready_i    = ($urandom_range(0, 99) < ready_pct);
    rv            = (pending.size() != 0) && (pending[0].due <= cyc);
    mem_rvalid_i  = rv;
    mem_rdata_i   = rv ? mem_word(pending[0].addr) : INSTR_NOP;
    mem_gnt_i     = ($urandom_range(0, 99) < gnt_pct);
    #1;
    exp_req = started && !redir && (mq.size() + live_pending() < DEPTH) && (pending.size() < MAXO);
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr_o, exp_fetch);
    chk("pf_valid", 32'(pf_valid_o), 32'(mq.size() != 0));
    if (pf_valid_o && mq.size() != 0) begin
      chk("pf_pc", pf_pc_o, mq[0]);
      chk("pf_instr", pf_instr_o, mem_word(mq[0]));
    end
    grant   = mem_req_o && mem_gnt_i;
    popping = pf_valid_o && pf_ready_i;
    keep    = 0;
    if (rv) begin
      r    = pending.pop_front();
      keep = (r.epoch == epoch);
    end
    if (redir) begin
      mq.delete();
      epoch++;
      exp_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (popping && mq.size() != 0) begin
        void'(mq.pop_front());
        pops++;
      end
      if (keep) mq.push_back(r.addr);
      if (grant) begin
        pending.push_back('{addr: exp_fetch, epoch: epoch,
                            due: cyc + 1 + $urandom_range(lat_min, lat_max)});
        grant_log.push_back(mem_addr_o);
        exp_fetch += 32'd4;
      end
    end
    chk("outstanding_bound", 32'(pending.size() <= MAXO), 32'd1);
    chk("fifo_bound", 32'(mq.size() <= DEPTH), 32'd1);
    started = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_i = 1'b0; pf_ready_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = INSTR_NOP;
    @(posedge clk);
    #1;
    chk("rst_pf_valid", 32'(pf_valid_o), 32'd0);
    chk("rst_pf_instr", pf_instr_o, 32'd0);
    chk("rst_pf_pc", pf_pc_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pending.delete(); mq.delete(); grant_log.delete();
    exp_fetch = RESET_PC; started = 0; epoch++;
  endtask

  task automatic wait_valid(input int unsigned limit);
    for (int unsigned i = 0; i < limit && !pf_valid_o; i++) cycle(1'b0, '0);
    chk("wait_valid", 32'(pf_valid_o), 32'd1);
  endtask

  typedef struct {
    bit redir; logic [31:0] rpc; bit ready; bit gnt; bit rv; logic [31:0] rdata;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t v(input bit redir, input logic [31:0] rpc, input bit ready,
                             input bit gnt, input bit rv, input logic [31:0] rdata,
                             input bit e_req, input logic [31:0] e_addr,
                             input bit e_valid, input logic [31:0] e_pc);
    return '{redir, rpc, ready, gnt, rv, rdata, e_req, e_addr, e_valid, e_pc};
  endfunction

  initial begin
    vec_t tbl[13];
    int unsigned p0;
    int unsigned n;

    // Fill with ready low, memory granting every cycle and answering one cycle later.
    tbl[0]  = v(0, 0,     0, 1, 0, 0,           0, 32'h000, 0, 0);
    tbl[1]  = v(0, 0,     0, 1, 0, 0,           1, 32'h000, 0, 0);
    tbl[2]  = v(0, 0,     0, 1, 1, mem_word(0), 1, 32'h004, 0, 0);
    tbl[3]  = v(0, 0,     0, 1, 1, mem_word(4), 1, 32'h008, 1, 0);
    tbl[4]  = v(0, 0,     0, 1, 1, mem_word(8), 1, 32'h00C, 1, 0);
    tbl[5]  = v(0, 0,     0, 1, 1, mem_word(12),0, 32'h010, 1, 0);
    tbl[6]  = v(0, 0,     0, 0, 0, 0,           0, 32'h010, 1, 0);
    tbl[7]  = v(0, 0,     1, 0, 0, 0,           0, 32'h010, 1, 0);
    tbl[8]  = v(0, 0,     0, 0, 0, 0,           1, 32'h010, 1, 4);
    tbl[9]  = v(1, 32'h203, 0, 1, 0, 0,         0, 32'h010, 1, 4);
    tbl[10] = v(0, 0,     0, 0, 0, 0,           1, 32'h200, 0, 0);
    tbl[11] = v(0, 0,     0, 1, 0, 0,           1, 32'h200, 0, 0);
    tbl[12] = v(0, 0,     0, 0, 0, 0,           1, 32'h204, 0, 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc; pf_ready_i = tbl[i].ready;
      mem_gnt_i = tbl[i].gnt; mem_rvalid_i = tbl[i].rv; mem_rdata_i = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d_req", i), 32'(mem_req_o), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_addr", i), mem_addr_o, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), 32'(pf_valid_o), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_pc", i), pf_pc_o, tbl[i].e_pc);
        chk($sformatf("row%0d_instr", i), pf_instr_o, mem_word(tbl[i].e_pc));
      end
      @(posedge clk);
      #1;
    end

    // Zero-wait memory, core always ready: one beat per cycle once filled.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);
    p0 = pops;
    for (int i = 0; i < 40; i++) cycle(1'b0, '0);
    chk("stream_rate", pops - p0, 32'd40);

    // Two slow requests in flight at 0x10/0x14, then redirect to 0x203.
    do_reset();
    gnt_pct = 100; ready_pct = 0; lat_min = 5; lat_max = 5;
    cycle(1'b1, 32'h10);
    grant_log.delete();
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk("two_out_n", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("two_out_a0", grant_log[0], 32'h10);
      chk("two_out_a1", grant_log[1], 32'h14);
    end
    cycle(1'b1, 32'h203);
    wait_valid(40);
    chk("redir_pc", pf_pc_o, 32'h200);
    chk("redir_instr", pf_instr_o, mem_word(32'h200));
    chk("redir_discard", 32'(dut.discard), 32'd0);

    // Redirect while a response and a grant are present, then again two cycles later.
    do_reset();
    gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0);
    chk("pre_redir_rvalid", 32'(pending.size() != 0 && pending[0].due <= cyc), 32'd1);
    cycle(1'b1, 32'h300);
    cycle(1'b0, '0);
    cycle(1'b1, 32'h400);
    wait_valid(20);
    chk("second_redir_pc", pf_pc_o, 32'h400);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0);

    // Address wrap, then reset in the middle of the stream.
    gnt_pct = 100; ready_pct = 100; lat_min = 0; lat_max = 1;
    grant_log.delete();
    cycle(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0);
    chk("wrap_n", 32'(grant_log.size() >= 3), 32'd1);
    if (grant_log.size() >= 3) begin
      chk("wrap_a0", grant_log[0], 32'hFFFF_FFF8);
      chk("wrap_a1", grant_log[1], 32'hFFFF_FFFC);
      chk("wrap_a2", grant_log[2], 32'h0000_0000);
    end
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, '0);

    // Randomized stalls, backpressure and occasional redirects.
    do_reset();
    gnt_pct = 60; ready_pct = 70; lat_min = 0; lat_max = 5;
    p0 = pops;
    n = 0;
    while ((pops - p0) < 10000 && n < 70000) begin
      if ($urandom_range(0, 99) == 0) cycle(1'b1, $urandom);
      else cycle(1'b0, '0);
      n++;
    end
    chk("random_done", 32'((pops - p0) >= 10000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
Name: if_prefetch_buf

Overview:
- Instruction prefetch queue between the core's fetch stage and the instruction memory/bus.
- Fetches sequential 32-bit words ahead of the core from a redirect PC and buffers them in a DEPTH-entry FIFO.
- Tracks outstanding memory requests, and silently discards responses that belong to a stream killed by a redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- pf_ready_i  in  1  core consumes the head entry.
- pf_valid_o  out  1  head entry is valid.
- pf_instr_o  out  32  head instruction word.
- pf_pc_o  out  32  PC of the head instruction.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  32  word-aligned request address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses return in order.
- mem_rdata_i  in  32  read data.

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, pf_valid_o=0, mem_req_o=0, mem_addr_o=RESET_PC, pf_instr_o/pf_pc_o=0. The first request is raised in the cycle after rst_n is released.
- Issue rule: mem_req_o = (count + outstanding - discard) < DEPTH and outstanding < MAX_OUTSTANDING and !redirect_i.
  - mem_addr_o = fetch_pc.
  - Both outputs are driven combinationally from registers.
- Grant handshake:
  - Request accepted when mem_req_o && mem_gnt_i.
  - On acceptance: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding++.
  - Request/address may change before grant only because of a redirect.
- Response handling: on mem_rvalid_i, outstanding--.
  - If discard>0: discard--, data dropped.
  - Else: {fetch-order PC, rdata} pushed to FIFO. The response PC comes from a per-request PC queue or from resp_pc counting (implementer's choice).
  - Pushed data is visible on pf_* the next cycle (1-cycle latency rvalid -> pf_valid_o).
- Pop: pf_valid_o && pf_ready_i removes the head. Push and pop in the same cycle are allowed at any occupancy.
- FIFO never overflows: the issue rule reserves space for every live outstanding request. Full is count==DEPTH; pop when empty is ignored.
- Redirect at cycle T:
  - FIFO cleared; pf_valid_o=0 at T+1.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - discard <= outstanding + (grant@T) - (rvalid@T). This includes all in-flight old-stream requests; a non-discarded rvalid at T is also dropped.
  - No request issued at T. The first new-stream request is at T+1.
  - Redirect overrides a simultaneous pop and push.
- Back-to-back redirects: the last one wins; discard is recomputed each time, so it accumulates correctly.
- Counters: outstanding and discard are clog2(MAX_OUTSTANDING+1) bits; discard <= outstanding always holds.
- mem_rvalid_i with outstanding==0 is a protocol error: ignored, with an assertion in simulation.

Decomposition:
- Shared package holds:
  - typedef type_if2imem_s / type_imem2if_s extended with gnt/rvalid.
  - typedef type_pf_entry_s {pc, instr}.
  - INSTR_NOP constant.
- Natural sub-module: pf_sync_fifo (parameterised DEPTH, type_pf_entry_s payload, push/pop/clear, count).
- Outstanding/discard bookkeeping and the issue logic stay in the top.

Test Plan:
- Reset, memory with grant=1 and rvalid 1 cycle after grant, pf_ready_i=0 → addresses 0,4,8,C issued, then mem_req_o=0. FIFO holds 4 entries, head pc=0.
- Steady stream with pf_ready_i=1 and zero-wait memory → one pf_valid_o beat per cycle after fill, PCs 0,4,8… contiguous, no gaps or duplicates.
- Two requests outstanding (addresses 0x10, 0x14), redirect to 0x203 → both old responses dropped. Next pf_pc_o=0x200 with the data for 0x200; discard returns to 0.
- Redirect in the same cycle as rvalid and grant, followed by a second redirect to 0x400 two cycles later → only 0x400-stream data appears.
- Random grant/rvalid stalls (0–5 cycles) with random pf_ready_i over 10k instructions → the core-side PC sequence matches the reference model, outstanding never exceeds MAX_OUTSTANDING, and the FIFO never overflows.
- Redirect to 0xFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_n asserted mid-stream → all outputs return to reset values next cycle.
